digitube_scan_ctrl: RTL and testbench

Scan controller for the four-digit seven-segment display. It latches a 16-bit hex value with per-digit decimal-point and blank masks, then rotates through the four digits at a programmable rate. It emits the 12-bit scanning-tube word: AN3..AN0 one-hot in [11:8], DP in [7], CG..CA in [6:0]. It sits between the CPU's display register and the board-level tube adapter. New values take effect only on frame boundaries, so a displayed number never tears.

---
 rtl/digitube_scan_ctrl_if.sv | 31 +++
 rtl/digitube_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_digitube_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/digitube_scan_ctrl_if.sv
// Bus between the CPU display register and the scan controller.
// master = CPU side, slave = scan controller.
interface digitube_scan_ctrl_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [11:0] digi_out;

    modport master (
        output data_in,
        output dp_in,
        output blank_in,
        output load,
        input  pending,
        input  frame_done,
        input  digi_out
    );

    modport slave (
        input  data_in,
        input  dp_in,
        input  blank_in,
        input  load,
        output pending,
        output frame_done,
        output digi_out
    );
endinterface

// File: rtl/digitube_scan_ctrl.sv
// Four-digit seven-segment scan controller with shadow/display register sets so that
// new values only take effect on frame boundaries.
module digitube_scan_ctrl #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    digitube_scan_ctrl_if.slave  bus
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic            frame_done_q, frame_done_d;
    logic [15:0]     sh_data_q, sh_data_d;
    logic [3:0]      sh_dp_q, sh_dp_d;
    logic [3:0]      sh_blank_q, sh_blank_d;
    logic [15:0]     dsp_data_q, dsp_data_d;
    logic [3:0]      dsp_dp_q, dsp_dp_d;
    logic [3:0]      dsp_blank_q, dsp_blank_d;
    logic [11:0]     digi_out_q, digi_out_d;

    logic            tick;
    logic            boundary;
    logic [3:0]      nib;
    logic            sel_dp;
    logic            sel_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (div_cnt_q == CntMax);
        boundary  = tick && (idx_q == 2'd3);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;

        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (bus.load) begin
            sh_data_d  = bus.data_in;
            sh_dp_d    = bus.dp_in;
            sh_blank_d = bus.blank_in;
        end

        // A load coinciding with the boundary bypasses the shadow set entirely.
        dsp_data_d  = dsp_data_q;
        dsp_dp_d    = dsp_dp_q;
        dsp_blank_d = dsp_blank_q;
        if (boundary && bus.load) begin
            dsp_data_d  = bus.data_in;
            dsp_dp_d    = bus.dp_in;
            dsp_blank_d = bus.blank_in;
        end else if (boundary && pending_q) begin
            dsp_data_d  = sh_data_q;
            dsp_dp_d    = sh_dp_q;
            dsp_blank_d = sh_blank_q;
        end

        if (boundary) begin
            pending_d = 1'b0;
        end else if (bus.load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        frame_done_d = boundary;

        // Output word is built from next-state values so anode and segments move together.
        nib       = dsp_data_d[idx_d*4 +: 4];
        sel_dp    = dsp_dp_d[idx_d];
        sel_blank = dsp_blank_d[idx_d];
        digi_out_d[11:8] = 4'b0001 << idx_d;
        if (sel_blank) begin
            digi_out_d[7:0] = 8'hFF;
        end else begin
            digi_out_d[7:0] = {~sel_dp, hex_to_seg(nib)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            dsp_data_q   <= '0;
            dsp_dp_q     <= '0;
            dsp_blank_q  <= '0;
            digi_out_q   <= 12'h1C0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            dsp_data_q   <= dsp_data_d;
            dsp_dp_q     <= dsp_dp_d;
            dsp_blank_q  <= dsp_blank_d;
            digi_out_q   <= digi_out_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign bus.digi_out   = digi_out_q;

    anode_onehot_a: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot(digi_out_q[11:8]));

endmodule

// File: tb/tb_digitube_scan_ctrl.sv
// Self-checking bench: cycle-count based reference model compared every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_digitube_scan_ctrl;

    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    digitube_scan_ctrl_if bus_if();

    digitube_scan_ctrl #(
        .CLK_DIV(DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if.slave)
    );

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    logic [6:0] seg_tab [16];

    // Reference model state
    int          m_cnt;
    logic [15:0] m_sh_data, m_d_data;
    logic [3:0]  m_sh_dp, m_d_dp, m_sh_blank, m_d_blank;
    logic        m_pend, m_fd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] expect_word(input int cnt, input logic [15:0] d,
                                                input logic [3:0] dp, input logic [3:0] bl);
        int         idx;
        logic [3:0] an;
        logic [3:0] n;
        idx = (cnt / DIV) % 4;
        an  = 4'(1 << idx);
        n   = 4'((d >> (4 * idx)) & 16'hF);
        if (bl[idx]) return {an, 8'hFF};
        return {an, ~dp[idx], seg_tab[n]};
    endfunction

    always @(posedge clk) begin
        if (!reset_n) edge_n = 0;
        else edge_n = edge_n + 1;
    end

    always @(posedge clk) begin
        logic bnd;
        if (!reset_n) begin
            m_cnt = 0;
            m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '0;
            m_d_data = '0;  m_d_dp = '0;  m_d_blank = '0;
            m_pend = 1'b0;  m_fd = 1'b0;
        end else begin
            bnd = ((m_cnt % (4 * DIV)) == (4 * DIV - 1));
            if (bus_if.load) begin
                m_sh_data = bus_if.data_in;
                m_sh_dp = bus_if.dp_in;
                m_sh_blank = bus_if.blank_in;
            end
            if (bnd) begin
                if (bus_if.load) begin
                    m_d_data = bus_if.data_in;
                    m_d_dp = bus_if.dp_in;
                    m_d_blank = bus_if.blank_in;
                end else if (m_pend) begin
                    m_d_data = m_sh_data;
                    m_d_dp = m_sh_dp;
                    m_d_blank = m_sh_blank;
                end
                m_pend = 1'b0;
            end else if (bus_if.load) begin
                m_pend = 1'b1;
            end
            m_fd = bnd;
            m_cnt++;
        end
        #1;
        chk("model_digi_out", 32'(bus_if.digi_out), 32'(expect_word(m_cnt, m_d_data, m_d_dp, m_d_blank)));
        chk("model_pending", 32'(bus_if.pending), 32'(m_pend));
        chk("model_frame_done", 32'(bus_if.frame_done), 32'(m_fd));
    end

    task automatic at_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl);
        bus_if.load = ld;
        bus_if.data_in = d;
        bus_if.dp_in = dp;
        bus_if.blank_in = bl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        drive(1'b0, 16'h0, 4'h0, 4'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_digi_out", 32'(bus_if.digi_out), 32'h1C0);
        chk("reset_pending", 32'(bus_if.pending), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        at_edge(4);  chk("anode_e4", 32'(bus_if.digi_out[11:8]), 32'h2);
        at_edge(8);  chk("anode_e8", 32'(bus_if.digi_out[11:8]), 32'h4);
        at_edge(12); chk("anode_e12", 32'(bus_if.digi_out[11:8]), 32'h8);
        at_edge(16); chk("anode_e16", 32'(bus_if.digi_out[11:8]), 32'h1);
        chk("frame_done_e16", 32'(bus_if.frame_done), 32'h1);

        // Mid-frame load of 0x1234 with DP on digit 1
        @(negedge clk); drive(1'b1, 16'h1234, 4'b0010, 4'b0000);
        at_edge(17); @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        chk("pending_after_load", 32'(bus_if.pending), 32'h1);
        at_edge(31); chk("pending_before_bnd", 32'(bus_if.pending), 32'h1);
        at_edge(32);
        chk("pending_at_bnd", 32'(bus_if.pending), 32'h0);
        chk("digit0_1234", 32'(bus_if.digi_out), 32'h199);
        at_edge(36); chk("digit1_1234", 32'(bus_if.digi_out), 32'h230);
        at_edge(40); chk("digit2_1234", 32'(bus_if.digi_out), 32'h4A4);
        at_edge(44); chk("digit3_1234", 32'(bus_if.digi_out), 32'h8F9);

        // Two loads in one frame: last wins
        @(negedge clk); drive(1'b1, 16'hAAAA, 4'h0, 4'h0);
        at_edge(45); @(negedge clk); drive(1'b1, 16'hFFFF, 4'h0, 4'h0);
        at_edge(46); @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        at_edge(47); chk("pending_two_loads", 32'(bus_if.pending), 32'h1);
        at_edge(48); chk("digit0_ffff", 32'(bus_if.digi_out), 32'h18E);
        at_edge(52); chk("digit1_ffff", 32'(bus_if.digi_out), 32'h28E);

        // Load exactly on the boundary cycle
        at_edge(63); @(negedge clk); drive(1'b1, 16'h8888, 4'h0, 4'h0);
        at_edge(64);
        chk("digit0_bnd_load", 32'(bus_if.digi_out), 32'h180);
        chk("pending_bnd_load", 32'(bus_if.pending), 32'h0);
        @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        at_edge(65); chk("pending_after_bnd_load", 32'(bus_if.pending), 32'h0);

        // Blank digits 0 and 2, DP requested everywhere
        @(negedge clk); drive(1'b1, 16'h5678, 4'b1111, 4'b0101);
        at_edge(66); @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        at_edge(80); chk("blank_digit0", 32'(bus_if.digi_out), 32'h1FF);
        at_edge(84); chk("dp_digit1", 32'(bus_if.digi_out), 32'h278);
        at_edge(88); chk("blank_digit2", 32'(bus_if.digi_out), 32'h4FF);
        at_edge(92); chk("dp_digit3", 32'(bus_if.digi_out), 32'h812);

        // Async reset while a value is pending; loads during reset are ignored
        at_edge(93); @(negedge clk); drive(1'b1, 16'h1111, 4'h0, 4'h0);
        at_edge(94); @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        chk("pending_before_rst", 32'(bus_if.pending), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pending", 32'(bus_if.pending), 32'h0);
        chk("async_rst_digi_out", 32'(bus_if.digi_out), 32'h1C0);
        @(negedge clk); drive(1'b1, 16'hBEEF, 4'hF, 4'h0);
        @(negedge clk); @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        at_edge(1);  chk("pending_rst_load_ignored", 32'(bus_if.pending), 32'h0);
        at_edge(16); chk("digit0_after_rst", 32'(bus_if.digi_out), 32'h1C0);

        // Randomized traffic, including one reset pulse, checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
            if (i == 1500) reset_n = 1'b0;
            if (i == 1503) reset_n = 1'b1;
        end
        @(negedge clk); drive(1'b0, 16'h0, 4'h0, 4'h0);
        repeat (20) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
